// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider_sign_adj.sv
// Conditional two's-complement negator, used for operand magnitudes and result signs.
module divider_sign_adj #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/divider.sv
// Radix-2 restoring divider: quotient on lo_out, remainder on hi_out, 34-edge latency.
// Handshake: ena_sig is a start request sampled only in IDLE; busy_out is high while
// an operation runs; done_out pulses for one cycle when hi_out/lo_out/div_zero_out update.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  input  logic             ena_sig,
  input  logic             sign_flag,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             div_zero_out
);

  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] orig_a;
  logic             neg_q, neg_r, zero_b;

  logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]   shifted, trial;

  divider_sign_adj #(.WIDTH(WIDTH)) u_mag_a (
    .value(op_a), .negate(sign_flag & op_a[WIDTH-1]), .result(mag_a)
  );
  divider_sign_adj #(.WIDTH(WIDTH)) u_mag_b (
    .value(op_b), .negate(sign_flag & op_b[WIDTH-1]), .result(mag_b)
  );
  divider_sign_adj #(.WIDTH(WIDTH)) u_fix_q (
    .value(quo), .negate(neg_q), .result(quo_fix)
  );
  divider_sign_adj #(.WIDTH(WIDTH)) u_fix_r (
    .value(rem), .negate(neg_r), .result(rem_fix)
  );

  // The remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
  // and the trial difference's top bit is its sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_mag};

  assign busy_out = (state != DIV_IDLE);

  always_ff @(posedge clk_sig) begin
    if (rst_sig) state <= DIV_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (ena_sig) state_next = DIV_CALC;
      DIV_CALC: if (cnt == CNT_LAST) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      cnt          <= '0;
      quo          <= '0;
      rem          <= '0;
      div_mag      <= '0;
      orig_a       <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      zero_b       <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
      done_out     <= 1'b0;
      div_zero_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (ena_sig) begin
            quo     <= mag_a;
            div_mag <= mag_b;
            orig_a  <= op_a;
            neg_q   <= sign_flag & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r   <= sign_flag & op_a[WIDTH-1];
            zero_b  <= (op_b == '0);
            rem     <= '0;
            cnt     <= '0;
          end
        end
        DIV_CALC: begin
          // quo doubles as the dividend shift register; quotient bits enter at the bottom.
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        DIV_FIX: begin
          if (zero_b) begin
            lo_out <= DIV_ZERO_QUOT;
            hi_out <= orig_a;
          end else begin
            lo_out <= quo_fix;
            hi_out <= rem_fix;
          end
          div_zero_out <= zero_b;
          done_out     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, handshake/reset sequences, random ops.
module tb_divider;

  logic        clk_sig = 1'b0;
  logic        rst_sig = 1'b1;
  logic        ena_sig = 1'b0;
  logic        sign_flag = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] hi_out, lo_out;
  logic        busy_out, done_out, div_zero_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
  } vec_t;

  vec_t vecs[11];
  logic [64:0] exp_q[$];

  divider #(.WIDTH(32)) dut (
    .clk_sig(clk_sig), .rst_sig(rst_sig), .ena_sig(ena_sig), .sign_flag(sign_flag),
    .op_a(op_a), .op_b(op_b), .hi_out(hi_out), .lo_out(lo_out),
    .busy_out(busy_out), .done_out(done_out), .div_zero_out(div_zero_out)
  );

  // clock/reset
  always #5 clk_sig = ~clk_sig;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic in 64 bits; returns {div_zero, rem, quot}.
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // driver: pulse ena for one edge (E0); returns at the falling edge after E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk_sig);
    op_a = a;
    op_b = b;
    sign_flag = sgn;
    ena_sig = 1'b1;
    @(negedge clk_sig);
    ena_sig = 1'b0;
  endtask

  // Counts edges after E0 until done_out is seen; poke_at >= 0 pulses a stray start.
  task automatic wait_done(input int poke_at, output int edges, output int busy_cnt,
                           output bit ok);
    edges = 0;
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy_out) busy_cnt++;
      if (done_out) begin
        ok = 1'b1;
        break;
      end
      if (poke_at >= 0) begin
        ena_sig = (i == poke_at);
        if (i == poke_at) begin
          op_a = 32'd50;
          op_b = 32'd5;
        end
      end
      @(negedge clk_sig);
      edges++;
    end
    if (poke_at >= 0) ena_sig = 1'b0;
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                              input logic z);
    check({tag, "_lo"}, lo_out, lo);
    check({tag, "_hi"}, hi_out, hi);
    check({tag, "_dz"}, 32'(div_zero_out), 32'(z));
  endtask

  initial begin
    int edges, busy_cnt;
    bit ok;
    logic [64:0] e;
    logic [31:0] ra, rb;
    logic rs;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[4]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[5]  = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[6]  = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[8]  = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0};
    vecs[9]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0};
    vecs[10] = '{32'hFFFF_FFF0,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1};

    // reset state
    repeat (3) @(negedge clk_sig);
    rst_sig = 1'b0;
    check_result("reset", 32'd0, 32'd0, 1'b0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_done", 32'(done_out), 32'd0);

    // directed table
    foreach (vecs[k]) begin
      start_op(vecs[k].a, vecs[k].b, vecs[k].sgn);
      wait_done(-1, edges, busy_cnt, ok);
      // accept edge plus 33 more: 34 edges in total
      check($sformatf("v%0d_latency", k), 32'(edges), 32'd33);
      check($sformatf("v%0d_busy_cycles", k), 32'(busy_cnt), 32'd33);
      check($sformatf("v%0d_busy_at_done", k), 32'(busy_out), 32'd0);
      check_result($sformatf("v%0d", k), vecs[k].lo, vecs[k].hi, vecs[k].z);
      @(negedge clk_sig);
      check($sformatf("v%0d_done_width", k), 32'(done_out), 32'd0);
      check_result($sformatf("v%0d_hold", k), vecs[k].lo, vecs[k].hi, vecs[k].z);
    end

    // stray start at cycle 10 is ignored
    start_op(32'd100, 32'd7, 1'b0);
    wait_done(9, edges, busy_cnt, ok);
    check("ignore_latency", 32'(edges), 32'd33);
    check_result("ignore", 32'd14, 32'd2, 1'b0);

    // ena held through the done cycle: new operands must not disturb the running op
    start_op(32'd100, 32'd7, 1'b0);
    op_a = 32'd20;
    op_b = 32'd3;
    ena_sig = 1'b1;
    wait_done(-1, edges, busy_cnt, ok);
    check_result("hold_first", 32'd14, 32'd2, 1'b0);
    @(negedge clk_sig);
    ena_sig = 1'b0;
    check("hold_restart_busy", 32'(busy_out), 32'd1);
    check("hold_restart_done", 32'(done_out), 32'd0);
    wait_done(-1, edges, busy_cnt, ok);
    check("hold_second_latency", 32'(edges), 32'd33);
    check_result("hold_second", 32'd6, 32'd2, 1'b0);

    // reset mid-operation
    start_op(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk_sig);
    rst_sig = 1'b1;
    @(negedge clk_sig);
    rst_sig = 1'b0;
    check_result("midrst", 32'd0, 32'd0, 1'b0);
    check("midrst_busy", 32'(busy_out), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_out || busy_out) ok = 1'b1;
      @(negedge clk_sig);
    end
    check("midrst_quiet", 32'(ok), 32'd0);
    start_op(32'd1000, 32'd10, 1'b0);
    wait_done(-1, edges, busy_cnt, ok);
    check_result("after_rst", 32'd100, 32'd0, 1'b0);

    // randomized ops against the reference model via the expected queue
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 255);
        3:       rb = 32'd0 - 32'($urandom_range(1, 255));
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_div(ra, rb, rs));
      start_op(ra, rb, rs);
      wait_done(-1, edges, busy_cnt, ok);
      e = exp_q.pop_front();
      check_result($sformatf("rnd%0d", n), e[31:0], e[63:32], e[64]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential radix-2 restoring integer divider. It is the inverse operation of the combinational multiplier and sits beside it in the ALU/HI-LO datapath.
- Takes a 32-bit dividend and divisor, signed or unsigned, and produces the quotient on lo_out and the remainder on hi_out.
- Multi-cycle with a start/busy/done handshake, so the pipeline stalls on busy_out.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clk_sig  in  1  clock; all state updates on rising edge
- rst_sig  in  1  synchronous active-high reset
- ena_sig  in  1  start request; sampled only in IDLE
- sign_flag  in  1  1 = signed (two's complement) division, 0 = unsigned; sampled with ena_sig
- op_a  in  32  dividend; sampled with ena_sig
- op_b  in  32  divisor; sampled with ena_sig
- hi_out  out  32  remainder of the last completed operation
- lo_out  out  32  quotient of the last completed operation
- busy_out  out  1  high while an operation is in progress
- done_out  out  1  one-cycle pulse when hi_out/lo_out update
- div_zero_out  out  1  latched with results; 1 if the last op had op_b == 0

Behaviour:
- Reset: rst_sig=1 at an edge puts the FSM in IDLE. hi_out, lo_out, busy_out, done_out and div_zero_out all become 0, and internal registers clear.
- Reset has priority over ena_sig. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On an edge with ena_sig=1, capture sign_flag, op_a, op_b and the original op_a.
  - Compute the magnitudes |op_a| and |op_b| when sign_flag=1 and the MSB is set; otherwise use the raw values.
  - Record neg_q = sign_flag & (op_a[31] ^ op_b[31]) and neg_r = sign_flag & op_a[31].
  - Clear the partial remainder and the iteration counter, then go to CALC.
  - busy_out rises after this edge.
- CALC, one quotient bit per edge, 32 edges in total:
  - Shift partial remainder (33 bits) left, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift a 1 into the quotient; otherwise restore and shift a 0.
  - After the counter reaches 31, go to FIX.
- FIX, one edge:
  - Apply signs: quotient negated if neg_q, remainder negated if neg_r.
  - Write lo_out and hi_out, set div_zero_out, assert done_out, go to IDLE.
- Latency: accept edge E0, iterations at E1..E32, FIX write at E33. done_out=1 and busy_out=0 during the cycle after E33, so the total is 34 edges.
- done_out is exactly one cycle wide.
- hi_out, lo_out and div_zero_out hold until the next FIX or reset.
- ena_sig while busy_out=1 is ignored; it is not queued. A new start is accepted in the same cycle done_out is high, because the FSM is in IDLE. Operand changes during busy have no effect.
- Rounding: truncation toward zero. Remainder carries the dividend's sign, and |rem| < |divisor|.
- Divide by zero (op_b == 0, either mode): full latency is kept. FIX forces lo_out = 32'hFFFFFFFF, hi_out = original op_a, div_zero_out = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo_out = 0x80000000, hi_out = 0, div_zero_out = 0. This result falls out of the magnitude path with no special case.
- Zero dividend: lo_out = 0, hi_out = 0.
- Unsigned mode never negates, even with the MSB set.

Decomposition:
- Shared package (e.g. div_pkg) holds:
  - state encodings DIV_IDLE, DIV_CALC, DIV_FIX (2-bit)
  - DIV_ITER = 32
  - DIV_ZERO_QUOT = 32'hFFFFFFFF
- One natural sub-module, divider_sign_adj: a combinational conditional two's-complement negator (in: value, negate; out: result). It is instantiated for operand magnitude and for result sign fix.
- The iteration datapath stays in divider.

Test Plan:
- Unsigned: op_a=100, op_b=7, sign_flag=0, ena pulse. Required: done_out exactly 34 edges after accept, lo_out=14, hi_out=2, div_zero_out=0, busy_out high for 33 cycles.
- Signed: -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 7/-2 -> lo=0xFFFFFFFD, hi=1. Unsigned 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1.
- Divide by zero: op_a=5, op_b=0, both modes -> lo=0xFFFFFFFF, hi=5, div_zero_out=1 after 34 edges. A following 9/3 -> lo=3, hi=0, div_zero_out=0.
- Overflow: signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake: start 100/7, then ena_sig with 50/5 at cycle 10 is ignored (result 14/2). ena_sig held high through the done cycle starts a new op immediately, done again 34 edges later.
- Reset mid-op: rst_sig at cycle 15 -> all outputs 0, no done pulse. A subsequent 1000/10 completes normally -> lo=100, hi=0.
